bus_arbiter: RTL and testbench

//  Shares one single-ported memory bus between instruction fetch (IF) and data access (MEM).
//  MEM has fixed priority over IF because it holds the older instruction.

---
 rtl/bus_arbiter_pkg.sv | 29 ++
 rtl/arb_timeout_cnt.sv | 38 +++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared types and constants for the IF/MEM memory bus arbiter.
//   arb_state_e   : arbiter FSM states
//   ZERO_WORD     : all-zero bus word
//   INST_SEL_ALL  : byte enables used for every instruction fetch
//   BUS_TIMEOUT   : default number of bus cycles waited for an ack
//   is_bus_state  : true for states in which bus_req_o is asserted
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_D_WAIT = 3'd1,
        ARB_D_DONE = 3'd2,
        ARB_I_WAIT = 3'd3,
        ARB_I_DONE = 3'd4,
        ARB_I_DROP = 3'd5
    } arb_state_e;

    localparam logic [31:0] ZERO_WORD    = '0;
    localparam logic [3:0]  INST_SEL_ALL = 4'b1111;
    localparam int unsigned BUS_TIMEOUT  = 64;

    function automatic logic is_bus_state(input arb_state_e s);
        return s inside {ARB_D_WAIT, ARB_I_WAIT, ARB_I_DROP};
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// arb_timeout_cnt
// Saturating bus-cycle counter used to detect a slave that never acks.
//   i_clk      : clock, rising edge
//   i_rst      : synchronous reset, active-high
//   i_clear    : restart counting from 0 (entry into a bus-active state)
//   i_enable   : count this cycle (bus active, no ack)
//   o_expired  : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module arb_timeout_cnt
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = BUS_TIMEOUT,
    parameter int unsigned CNT_W   = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at LAST so a stuck enable can never wrap back to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one single-ported memory bus between instruction fetch (IF) and the
// MEM stage. MEM wins when both request together. Fetches cancelled by a
// branch flush are completed on the bus and their data discarded. A slave
// that does not ack within TIMEOUT bus cycles is forced to complete with zero
// data and a one-cycle bus_err_o pulse.
//   clk, rst                 : clock, synchronous active-high reset
//   if_req_i/if_addr_i       : fetch request and address
//   if_rdata_o/if_stallreq_o : fetched word / fetch not complete
//   flush_i                  : cancel the in-flight fetch
//   mem_ce_i/we/addr/wdata/sel : data access request
//   mem_rdata_o/mem_stallreq_o : load data / data access not complete
//   bus_req/we/addr/wdata/sel_o : registered bus master outputs
//   bus_ack_i/bus_rdata_i    : slave completion and read data
//   bus_err_o                : timeout pulse
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = BUS_TIMEOUT,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_stallreq_o,
    input  logic        flush_i,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    arb_state_e  r_state;
    arb_state_e  w_next;
    logic        w_in_bus;
    logic        w_expired;
    logic        w_timeout;
    logic        w_done;
    logic        w_enter_bus;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;

    // Ack is only meaningful while the bus is active; a timeout is treated
    // as a completion carrying zero data.
    assign w_in_bus    = is_bus_state(r_state);
    assign w_timeout   = w_in_bus & w_expired & ~bus_ack_i;
    assign w_done      = w_in_bus & (bus_ack_i | w_expired);
    assign w_enter_bus = is_bus_state(w_next) && (w_next != r_state);

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_enter_bus),
        .i_enable  (w_in_bus & ~bus_ack_i),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (mem_ce_i) begin
                    w_next = ARB_D_WAIT;
                end else if (if_req_i && !flush_i) begin
                    w_next = ARB_I_WAIT;
                end
            end
            ARB_D_WAIT: if (w_done) w_next = ARB_D_DONE;
            ARB_D_DONE: w_next = ARB_IDLE;
            ARB_I_WAIT: begin
                // A flush completing together with the ack needs no drain.
                if (flush_i) begin
                    w_next = w_done ? ARB_IDLE : ARB_I_DROP;
                end else if (w_done) begin
                    w_next = ARB_I_DONE;
                end
            end
            ARB_I_DONE: w_next = ARB_IDLE;
            ARB_I_DROP: if (w_done) w_next = ARB_IDLE;
            default:    w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= ZERO_WORD;
            r_bus_wdata <= ZERO_WORD;
            r_bus_sel   <= '0;
            r_if_rdata  <= ZERO_WORD;
            r_mem_rdata <= ZERO_WORD;
        end else begin
            r_bus_req <= is_bus_state(w_next);
            // Bus fields load only when leaving IDLE, keeping them stable
            // for the whole bus cycle.
            if (r_state == ARB_IDLE && w_next == ARB_D_WAIT) begin
                r_bus_we    <= mem_we_i;
                r_bus_addr  <= mem_addr_i;
                r_bus_wdata <= mem_wdata_i;
                r_bus_sel   <= mem_sel_i;
            end else if (r_state == ARB_IDLE && w_next == ARB_I_WAIT) begin
                r_bus_we    <= 1'b0;
                r_bus_addr  <= if_addr_i;
                r_bus_wdata <= ZERO_WORD;
                r_bus_sel   <= INST_SEL_ALL;
            end
            if (r_state == ARB_D_WAIT && w_done) begin
                r_mem_rdata <= (r_bus_we || w_timeout) ? ZERO_WORD : bus_rdata_i;
            end
            if (r_state == ARB_I_WAIT && w_done && !flush_i) begin
                r_if_rdata <= w_timeout ? ZERO_WORD : bus_rdata_i;
            end
        end
    end

    assign mem_stallreq_o = mem_ce_i & (r_state != ARB_D_DONE);
    assign if_stallreq_o  = if_req_i & (r_state != ARB_I_DONE);
    assign bus_err_o      = w_timeout;

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign bus_sel_o   = r_bus_sel;
    assign if_rdata_o  = r_if_rdata;
    assign mem_rdata_o = r_mem_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. Each sequence is described by when the
// slave acks (in bus cycles); the expected cycle-by-cycle stall, bus, error
// and read-data behaviour is derived from that timeline.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_stallreq_o;
    logic        flush_i;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_mem_rd;

    always #5 clk = ~clk;

    bus_arbiter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_rdata_o     (if_rdata_o),
        .if_stallreq_o  (if_stallreq_o),
        .flush_i        (flush_i),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_sel_i      (mem_sel_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_stallreq_o (mem_stallreq_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_sel_o      (bus_sel_o),
        .bus_ack_i      (bus_ack_i),
        .bus_rdata_i    (bus_rdata_i),
        .bus_err_o      (bus_err_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bus cycles occupied by an access whose slave acks in bus cycle 'ack'
    // (0 = never acks, so the timeout ends it in bus cycle TIMEOUT).
    function automatic int bus_len(input int ack);
        return (ack >= 1 && ack <= TIMEOUT) ? ack : TIMEOUT;
    endfunction

    // Cycle 0 is the cycle the request is first presented in IDLE.
    // Data (optional) runs first; an optional flushed fetch A follows; the
    // real fetch (at faddr, or faddr2 after a flush) runs last.
    task automatic run_seq(
        input bit do_d, input bit we, input logic [31:0] daddr,
        input logic [31:0] dwdata, input logic [3:0] dsel, input int dack,
        input bit do_f, input logic [31:0] faddr, input int fack,
        input bit do_flush, input int fl_at, input int fl_ack,
        input logic [31:0] faddr2);
        int ed, sf0, ea, fc, sf, ef, last;
        bit to_d, to_f, exp_req, fphase;
        logic [31:0] d_data, f_data, e_addr, cur_faddr;
        logic [3:0]  e_sel;
        logic        e_we;
        ed   = do_d ? bus_len(dack) : -2;
        to_d = !(dack >= 1 && dack <= TIMEOUT);
        sf0  = do_d ? ed + 2 : 0;
        ea   = do_flush ? sf0 + fl_ack : -2;
        fc   = do_flush ? sf0 + fl_at : -1;
        sf   = do_flush ? ea + 1 : sf0;
        ef   = sf + bus_len(fack);
        to_f = !(fack >= 1 && fack <= TIMEOUT);
        last = do_f ? ef + 1 : ed + 1;
        cur_faddr = do_flush ? faddr2 : faddr;
        d_data = '0;
        f_data = '0;
        mem_we_i    = we;
        mem_addr_i  = daddr;
        mem_wdata_i = dwdata;
        mem_sel_i   = dsel;
        for (int c = 0; c <= last + 1; c++) begin
            mem_ce_i    = do_d && (c <= ed + 1);
            if_req_i    = do_f && (c <= ef + 1);
            if_addr_i   = (do_flush && c >= fc) ? faddr2 : faddr;
            flush_i     = do_flush && (c == fc);
            bus_rdata_i = $urandom;
            bus_ack_i   = 1'b0;
            if (do_d && !to_d && c == dack) begin
                bus_ack_i = 1'b1;
                d_data    = bus_rdata_i;
            end
            if (do_flush && c == ea) bus_ack_i = 1'b1;
            if (do_f && !to_f && c == sf + fack) begin
                bus_ack_i = 1'b1;
                f_data    = bus_rdata_i;
            end
            // Stray acks while no bus cycle is active must be ignored.
            if ((do_d && c == ed + 1) || (do_f && c == ef + 1) || c == last + 1)
                bus_ack_i = 1'($urandom_range(0, 1));

            @(negedge clk);
            check_eq($sformatf("mem_stall c%0d", c), mem_stallreq_o, do_d && c <= ed);
            check_eq($sformatf("if_stall c%0d", c), if_stallreq_o,
                     if_req_i && !(do_f && c == ef + 1));
            exp_req = 1'b0;
            fphase  = 1'b0;
            e_we = 1'b0; e_sel = 4'hF; e_addr = '0;
            if (do_d && c >= 1 && c <= ed) begin
                exp_req = 1'b1; e_we = we; e_sel = dsel; e_addr = daddr;
            end else if (do_flush && c >= sf0 + 1 && c <= ea) begin
                exp_req = 1'b1; fphase = 1'b1; e_addr = faddr;
            end else if (do_f && c >= sf + 1 && c <= ef) begin
                exp_req = 1'b1; fphase = 1'b1; e_addr = cur_faddr;
            end
            if (exp_req)
                check_eq($sformatf("bus c%0d", c),
                         {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, fphase ? 32'h0 : bus_wdata_o},
                         {1'b1, e_we, e_sel, e_addr, fphase ? 32'h0 : dwdata});
            else
                check_eq($sformatf("bus_req c%0d", c), bus_req_o, 1'b0);
            check_eq($sformatf("bus_err c%0d", c), bus_err_o,
                     (do_d && to_d && c == ed) || (do_f && to_f && c == ef));
            if (do_d && c == ed + 1) begin
                exp_mem_rd = (to_d || we) ? 32'h0 : d_data;
                check_eq("mem_rdata", mem_rdata_o, exp_mem_rd);
            end
            if (do_flush && c == ea + 1)
                check_eq("if_rdata_kept", if_rdata_o, exp_if_rd);
            if (do_f && c == ef + 1) begin
                exp_if_rd = to_f ? 32'h0 : f_data;
                check_eq("if_rdata", if_rdata_o, exp_if_rd);
            end
            @(posedge clk);
            #1;
        end
        mem_ce_i  = 1'b0;
        if_req_i  = 1'b0;
        flush_i   = 1'b0;
        bus_ack_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bus"}, {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o}, '0);
        check_eq({tag, "_rdata"}, {if_rdata_o, mem_rdata_o}, '0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int kind, fl_at;
        rst = 1'b1;
        if_req_i = 0; if_addr_i = '0; flush_i = 0;
        mem_ce_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_sel_i = '0;
        bus_ack_i = 0; bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_stall", {mem_stallreq_o, if_stallreq_o}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_if_rd  = '0;
        exp_mem_rd = '0;

        // Fetch with ack in the first bus cycle.
        run_seq(0, 0, 0, 0, 0, 0,  1, 32'h0000_0010, 1,  0, 0, 0, 0);
        // Load and fetch together: data first, fetch after D_DONE.
        run_seq(1, 0, 32'h100, 32'h0, 4'hF, 1,  1, 32'h14, 1,  0, 0, 0, 0);
        // Store with ack in bus cycle 4.
        run_seq(1, 1, 32'h200, 32'h1234_5678, 4'hF, 4,  0, 0, 0,  0, 0, 0, 0);
        // Flush in I_WAIT, ack two cycles later, then refetch.
        run_seq(0, 0, 0, 0, 0, 0,  1, 32'h20, 1,  1, 1, 3, 32'h40);
        // Flush and ack in the same cycle.
        run_seq(0, 0, 0, 0, 0, 0,  1, 32'h24, 2,  1, 2, 2, 32'h80);
        // Load timeout.
        run_seq(1, 0, 32'h300, 32'h0, 4'hF, 0,  0, 0, 0,  0, 0, 0, 0);
        // Ack arriving exactly in the last bus cycle wins over timeout.
        run_seq(1, 0, 32'h304, 32'h0, 4'h3, TIMEOUT,  0, 0, 0,  0, 0, 0, 0);
        // Fetch timeout.
        run_seq(0, 0, 0, 0, 0, 0,  1, 32'h28, 0,  0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int dack, fack, flack;
            kind  = $urandom_range(0, 3);
            dack  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
            fack  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
            flack = $urandom_range(1, 4);
            fl_at = $urandom_range(1, flack);
            run_seq(kind == 0 || kind == 2 || (kind == 3 && $urandom_range(0, 1) == 1),
                    1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)), dack,
                    kind != 0, $urandom, fack,
                    kind == 3, fl_at, flack, $urandom);
        end

        // Reset in the middle of a data bus cycle.
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h500; mem_sel_i = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ce_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hA5A5_5A5A;
        @(negedge clk);
        check_eq("stray_ack_req", bus_req_o, 1'b0);
        @(posedge clk);
        #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        check_all_zero("stray_ack");
        @(posedge clk);
        #1;
        exp_if_rd  = '0;
        exp_mem_rd = '0;
        run_seq(1, 0, 32'h600, 32'h0, 4'hF, 2,  1, 32'h30, 1,  0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
